// File: rtl/pipe_sink_fifo.sv
// Storage ring and read/write pointers for the credit sink.
// Occupancy lives in the parent, so push/pop are assumed legal here.
module pipe_sink_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Rounded up to a power of two so any pointer value indexes a real slot;
  // slots at or above DEPTH are never written or read.
  localparam int SLOTS = 1 << PW;

  logic [DATA_WIDTH-1:0] r_mem [SLOTS];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointers advance modulo DEPTH on each push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push_i) r_wptr <= f_inc(r_wptr);
      if (pop_i)  r_rptr <= f_inc(r_rptr);
    end
  end

  // Payload storage; contents are meaningless while empty so no reset.
  always_ff @(posedge clk) begin
    if (push_i) r_mem[r_wptr] <= push_data_i;
  end

  assign rd_data_o = r_mem[r_rptr];
endmodule

// File: rtl/pipe_credit_sink.sv
// Credit-managed sink for a fixed-latency request/response pipe.
// Launches are granted only when buffer space is reserved for the reply,
// so the buffer never overflows under legal upstream behaviour.
module pipe_credit_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch_i,
  output logic                  launch_ok_o,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic                  err_o
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]         r_occ;
  logic [CW-1:0]         r_inflight;
  logic                  r_err;

  logic [CW:0]           w_sum;
  logic                  w_launch_ok;
  logic                  w_launch_acc;
  logic                  w_out_valid;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_covered;
  logic                  w_arrive;
  logic                  w_push;
  logic                  w_violation;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Credit is computed from registered counts only, so a pop frees a
  // credit one cycle later and there is no input-to-grant path.
  assign w_sum        = {1'b0, r_occ} + {1'b0, r_inflight};
  assign w_launch_ok  = w_sum < (CW+1)'(DEPTH);
  assign w_launch_acc = launch_i & w_launch_ok;

  assign w_out_valid  = (r_occ != '0);
  assign w_pop        = w_out_valid & out_ready_i;
  assign w_full       = (r_occ == CW'(DEPTH));

  // A beat is expected if something is in flight; with zero latency the
  // beat rides alongside its own accepted launch.
  assign w_covered    = (r_inflight != '0) | ((LATENCY == 0) & w_launch_acc);
  assign w_arrive     = data_valid_i & w_covered;
  assign w_push       = w_arrive & ~(w_full & ~w_pop);

  assign w_violation  = (launch_i & ~w_launch_ok)
                      | (data_valid_i & ~w_covered)
                      | (w_arrive & w_full & ~w_pop);

  // In-flight count: up on granted launch, down on expected arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_launch_acc, w_arrive})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Buffer occupancy: up on stored beat, down on delivered beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_err <= 1'b0;
    else if (w_violation) r_err <= 1'b1;
  end

  pipe_sink_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (data_i),
    .pop_i       (w_pop),
    .rd_data_o   (w_rd_data)
  );

  assign launch_ok_o = w_launch_ok;
  assign out_valid_o = w_out_valid;
  // Gate with valid so the unreset storage never shows on the output.
  assign out_data_o  = w_out_valid ? w_rd_data : '0;
  assign err_o       = r_err;
endmodule

// File: tb/tb_pipe_credit_sink.sv
// Directed bench: DEPTH=4/LATENCY=3 main instance with a delay-line
// upstream model and scoreboard, plus a DEPTH=1/LATENCY=0 streaming instance.
module tb_pipe_credit_sink;
  localparam int DW    = 32;
  localparam int LAT_A = 3;
  localparam int DEP_A = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A
  logic          launch_a, launch_ok_a, dv_a, out_valid_a, out_ready_a, err_a;
  logic [DW-1:0] data_a, out_data_a;
  logic          dv_force;
  logic [DW-1:0] force_data, launch_tag;
  // instance B
  logic          launch_b, launch_ok_b, dv_b, out_valid_b, out_ready_b, err_b;
  logic [DW-1:0] data_b, out_data_b;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_b[$];
  int n_cmp = 0;
  int n_bad = 0;

  // upstream model: launch-to-data delay line, squashed by reset
  logic [LAT_A:1]         vld_pipe;
  logic [LAT_A:1][DW-1:0] pd_pipe;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      pd_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT_A-1:1], launch_a & launch_ok_a};
      pd_pipe  <= {pd_pipe[LAT_A-1:1], launch_tag};
    end
  end
  assign dv_a   = vld_pipe[LAT_A] | dv_force;
  assign data_a = dv_force ? force_data : pd_pipe[LAT_A];

  pipe_credit_sink #(.DATA_WIDTH(DW), .LATENCY(LAT_A), .DEPTH(DEP_A)) dut_a (
    .clk(clk), .rst(rst), .launch_i(launch_a), .launch_ok_o(launch_ok_a),
    .data_valid_i(dv_a), .data_i(data_a), .out_valid_o(out_valid_a),
    .out_data_o(out_data_a), .out_ready_i(out_ready_a), .err_o(err_a));

  pipe_credit_sink #(.DATA_WIDTH(DW), .LATENCY(0), .DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .launch_i(launch_b), .launch_ok_o(launch_ok_b),
    .data_valid_i(dv_b), .data_i(data_b), .out_valid_o(out_valid_b),
    .out_data_o(out_data_b), .out_ready_i(out_ready_b), .err_o(err_b));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; launch_a = 0; out_ready_a = 0; dv_force = 0; force_data = '0; launch_tag = '0;
    launch_b = 0; dv_b = 0; data_b = '0; out_ready_b = 0;
    #2;
    n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_valid_a: got %b want 0", out_valid_a); end
    n_cmp++; if (launch_ok_a !== 1'b1) begin n_bad++; $display("FAIL rst_ok_a: got %b want 1", launch_ok_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL rst_err_a: got %b want 0", err_a); end
    n_cmp++; if (out_data_a !== 32'h0) begin n_bad++; $display("FAIL rst_data_a: got %h want 0", out_data_a); end
    n_cmp++; if (out_valid_b !== 1'b0) begin n_bad++; $display("FAIL rst_valid_b: got %b want 0", out_valid_b); end
    n_cmp++; if (launch_ok_b !== 1'b1) begin n_bad++; $display("FAIL rst_ok_b: got %b want 1", launch_ok_b); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    step();
    n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b want 0", out_valid_a); end
    n_cmp++; if (launch_ok_a !== 1'b1) begin n_bad++; $display("FAIL post_rst_ok: got %b want 1", launch_ok_a); end
    n_cmp++; if (out_data_a !== 32'h0) begin n_bad++; $display("FAIL post_rst_data: got %h want 0", out_data_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL post_rst_err: got %b want 0", err_a); end
  endtask

  task automatic test_fill_stall();
    int acc = 0;
    int first_low = -1;
    out_ready_a = 0;
    for (int c = 0; c < 8; c++) begin
      if (!launch_ok_a && first_low < 0) first_low = c;
      launch_a = launch_ok_a;
      if (launch_ok_a) begin
        launch_tag = 32'hA0 + acc;
        exp_q.push_back(launch_tag);
        acc++;
      end
      step();
    end
    launch_a = 0;
    n_cmp++; if (acc != 4) begin n_bad++; $display("FAIL fill_accepted: got %0d want 4", acc); end
    n_cmp++; if (first_low != 4) begin n_bad++; $display("FAIL fill_ok_low_cycle: got %0d want 4", first_low); end
    n_cmp++; if (launch_ok_a !== 1'b0) begin n_bad++; $display("FAIL fill_ok: got %b want 0", launch_ok_a); end
    n_cmp++; if (out_valid_a !== 1'b1) begin n_bad++; $display("FAIL fill_valid: got %b want 1", out_valid_a); end
    n_cmp++; if (dut_a.r_occ !== 3'd4) begin n_bad++; $display("FAIL fill_occ: got %0d want 4", dut_a.r_occ); end
    n_cmp++; if (dut_a.r_inflight !== 3'd0) begin n_bad++; $display("FAIL fill_inflight: got %0d want 0", dut_a.r_inflight); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL fill_err: got %b want 0", err_a); end
    n_cmp++; if (out_data_a !== 32'hA0) begin n_bad++; $display("FAIL fill_head: got %h want a0", out_data_a); end
  endtask

  task automatic test_drain();
    out_ready_a = 1;
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (out_valid_a !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b want 1", d, out_valid_a); end
      n_cmp++; if (out_data_a !== exp_q[0]) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", d, out_data_a, exp_q[0]); end
      n_cmp++; if (launch_ok_a !== (d != 0)) begin n_bad++; $display("FAIL drain_ok[%0d]: got %b want %b", d, launch_ok_a, (d != 0)); end
      void'(exp_q.pop_front());
      step();
    end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL drain_end_valid: got %b want 0", out_valid_a); end
    n_cmp++; if (launch_ok_a !== 1'b1) begin n_bad++; $display("FAIL drain_end_ok: got %b want 1", launch_ok_a); end
    out_ready_a = 0;
  endtask

  // push and pop together at the highest occupancy with a beat still due
  task automatic test_simul_push_pop();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (launch_ok_a !== 1'b1) begin n_bad++; $display("FAIL simul_ok[%0d]: got %b want 1", i, launch_ok_a); end
      launch_a = 1; launch_tag = 32'hB0 + i; exp_q.push_back(launch_tag);
      step();
    end
    launch_a = 0;
    step(); step();
    n_cmp++; if (dut_a.r_occ !== 3'd3) begin n_bad++; $display("FAIL simul_pre_occ: got %0d want 3", dut_a.r_occ); end
    n_cmp++; if (dut_a.r_inflight !== 3'd1) begin n_bad++; $display("FAIL simul_pre_inflight: got %0d want 1", dut_a.r_inflight); end
    out_ready_a = 1;
    n_cmp++; if (out_data_a !== exp_q[0]) begin n_bad++; $display("FAIL simul_head: got %h want %h", out_data_a, exp_q[0]); end
    void'(exp_q.pop_front());
    step();
    n_cmp++; if (dut_a.r_occ !== 3'd3) begin n_bad++; $display("FAIL simul_occ: got %0d want 3", dut_a.r_occ); end
    n_cmp++; if (dut_a.r_inflight !== 3'd0) begin n_bad++; $display("FAIL simul_inflight: got %0d want 0", dut_a.r_inflight); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (out_valid_a !== 1'b1) begin n_bad++; $display("FAIL simul_valid[%0d]: got %b want 1", k, out_valid_a); end
      n_cmp++; if (out_data_a !== exp_q[0]) begin n_bad++; $display("FAIL simul_data[%0d]: got %h want %h", k, out_data_a, exp_q[0]); end
      void'(exp_q.pop_front());
      step();
    end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL simul_end_valid: got %b want 0", out_valid_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL simul_err: got %b want 0", err_a); end
    out_ready_a = 0;
  endtask

  task automatic test_violations();
    dv_force = 1; force_data = 32'hDEAD;
    step();
    dv_force = 0;
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL viol_orphan_err: got %b want 1", err_a); end
    n_cmp++; if (dut_a.r_occ !== 3'd0) begin n_bad++; $display("FAIL viol_orphan_occ: got %0d want 0", dut_a.r_occ); end
    n_cmp++; if (dut_a.r_inflight !== 3'd0) begin n_bad++; $display("FAIL viol_orphan_inflight: got %0d want 0", dut_a.r_inflight); end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL viol_orphan_valid: got %b want 0", out_valid_a); end
    for (int i = 0; i < 4; i++) begin
      launch_a = 1; launch_tag = 32'hC0 + i; exp_q.push_back(launch_tag);
      step();
    end
    launch_a = 0;
    step(); step(); step();
    n_cmp++; if (launch_ok_a !== 1'b0) begin n_bad++; $display("FAIL viol_full_ok: got %b want 0", launch_ok_a); end
    launch_a = 1;
    step();
    launch_a = 0;
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL viol_launch_err: got %b want 1", err_a); end
    n_cmp++; if (dut_a.r_occ !== 3'd4) begin n_bad++; $display("FAIL viol_launch_occ: got %0d want 4", dut_a.r_occ); end
    n_cmp++; if (dut_a.r_inflight !== 3'd0) begin n_bad++; $display("FAIL viol_launch_inflight: got %0d want 0", dut_a.r_inflight); end
    n_cmp++; if (out_data_a !== 32'hC0) begin n_bad++; $display("FAIL viol_head: got %h want c0", out_data_a); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    step();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      launch_a = 1; launch_tag = 32'hD0 + i;
      step();
    end
    launch_a = 0;
    step(); step();
    n_cmp++; if (dut_a.r_occ !== 3'd2) begin n_bad++; $display("FAIL mid_pre_occ: got %0d want 2", dut_a.r_occ); end
    n_cmp++; if (dut_a.r_inflight !== 3'd1) begin n_bad++; $display("FAIL mid_pre_inflight: got %0d want 1", dut_a.r_inflight); end
    #2; rst = 1'b1;
    #1;
    n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", out_valid_a); end
    n_cmp++; if (launch_ok_a !== 1'b1) begin n_bad++; $display("FAIL mid_ok: got %b want 1", launch_ok_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", err_a); end
    n_cmp++; if (out_data_a !== 32'h0) begin n_bad++; $display("FAIL mid_data: got %h want 0", out_data_a); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    step();
    n_cmp++; if (dut_a.u_fifo.r_wptr !== 2'd0) begin n_bad++; $display("FAIL mid_wptr: got %0d want 0", dut_a.u_fifo.r_wptr); end
    n_cmp++; if (dut_a.u_fifo.r_rptr !== 2'd0) begin n_bad++; $display("FAIL mid_rptr: got %0d want 0", dut_a.u_fifo.r_rptr); end
    n_cmp++; if (dut_a.r_inflight !== 3'd0) begin n_bad++; $display("FAIL mid_inflight: got %0d want 0", dut_a.r_inflight); end
    // one beat after release: must not bypass the buffer
    launch_a = 1; launch_tag = 32'hE0;
    step();
    launch_a = 0;
    step(); step();
    n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL no_bypass_valid: got %b want 0", out_valid_a); end
    step();
    n_cmp++; if (out_valid_a !== 1'b1) begin n_bad++; $display("FAIL post_mid_valid: got %b want 1", out_valid_a); end
    n_cmp++; if (out_data_a !== 32'hE0) begin n_bad++; $display("FAIL post_mid_data: got %h want e0", out_data_a); end
    out_ready_a = 1;
    step();
    out_ready_a = 0;
  endtask

  task automatic test_latency0_stream();
    int pops = 0;
    out_ready_b = 1;
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (launch_ok_b !== (c % 2 == 0)) begin n_bad++; $display("FAIL l0_ok[%0d]: got %b want %b", c, launch_ok_b, (c % 2 == 0)); end
      n_cmp++; if (out_valid_b !== (c % 2 == 1)) begin n_bad++; $display("FAIL l0_valid[%0d]: got %b want %b", c, out_valid_b, (c % 2 == 1)); end
      if (out_valid_b && exp_b.size() > 0) begin
        n_cmp++; if (out_data_b !== exp_b[0]) begin n_bad++; $display("FAIL l0_data[%0d]: got %h want %h", c, out_data_b, exp_b[0]); end
        void'(exp_b.pop_front());
        pops++;
      end
      launch_b = launch_ok_b; dv_b = launch_ok_b;
      if (launch_ok_b) begin
        data_b = 32'hF0 + c;
        exp_b.push_back(data_b);
      end
      step();
    end
    launch_b = 0; dv_b = 0; out_ready_b = 0;
    n_cmp++; if (pops != 4) begin n_bad++; $display("FAIL l0_pops: got %0d want 4", pops); end
    n_cmp++; if (err_b !== 1'b0) begin n_bad++; $display("FAIL l0_err: got %b want 0", err_b); end
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_drain();
    test_simul_push_pop();
    test_latency0_stream();
    test_violations();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
